// File: rtl/imem_pkg.sv
// Shared constants, state encoding and helpers for the instruction-memory loader.
// Widths here are the single source of truth for word/byte sizing.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH     = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned LEN_W          = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } loader_state_e;

  // The requested length can never exceed what the target memory holds.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req,
                                                 input int unsigned      depth);
    if (32'(req) > depth) return LEN_W'(depth);
    return req;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into words: byte k lands in bits [8k+7:8k].
// full flags the push that completes the current word.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [BIDX_W-1:0] count_q;
  logic [WORD_W-1:0] word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      word_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
      word_q  <= '0;
    end else if (push) begin
      count_q <= count_q + BIDX_W'(1);
      word_q  <= {byte_in, word_q[WORD_W-1:BYTE_W]};
    end
  end

  // Shifting in from the top leaves the first byte in the low lane after four pushes.
  assign word = word_q;
  assign full = push && (count_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time while
// holding the core stalled; supports abort and clamps length to memory depth.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done
);

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [WORD_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

  logic              pk_clear;
  logic              pk_push;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word;
  logic [WORD_W-1:0] word_addr;

  // Acceptance depends only on registered state and inputs, never on full.
  assign pk_push   = (state_q == ST_RECV) && !abort && byte_valid;
  assign word_addr = {{(WORD_W - LEN_W - 2){1'b0}}, word_idx_q, 2'b00};

  byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pk_clear),
    .push    (pk_push),
    .byte_in (byte_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pk_clear   = 1'b0;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
    cpu_hold   = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          len_d      = clamp_len(load_len, DEPTH_WORDS);
          word_idx_d = '0;
          pk_clear   = 1'b1;
          state_d    = (len_d == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        cpu_hold = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          byte_ready = 1'b1;
          if (pk_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cpu_hold = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // Drive the live word this cycle and remember it for the hold period.
          wr_en      = 1'b1;
          wr_addr    = word_addr;
          wr_data    = pk_word;
          wr_addr_d  = word_addr;
          wr_data_d  = pk_word;
          word_idx_d = word_idx_q + LEN_W'(1);
          state_d    = (word_idx_d == len_q) ? ST_DONE : ST_RECV;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every wr_en strobe.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = '0;

  imem_loader #(.DEPTH_WORDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [4:0] len);
    @(negedge clk);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Returns at a negedge with the byte presented and byte_ready high, so the
  // following posedge accepts it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got byte_ready=%0b after 50 cycles, expected 1", byte_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_hold_in_done"}, 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          d0, w0;
    int          gaps[8];
    logic [31:0] stream[2];
    logic [31:0] w;

    gaps      = '{0, 3, 1, 2, 0, 3, 2, 1};
    stream[0] = 32'h1234_5678;
    stream[1] = 32'hABCD_EF00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    rst_n = 1'b1;

    // Two-word load, back-to-back bytes
    d0 = done_cnt;
    check("idle_hold", 32'(cpu_hold), 32'd0);
    do_start(5'd2);
    check("basic_hold_after_start", 32'(cpu_hold), 32'd1);
    expect_wr(32'h00, 32'h1234_5678);
    expect_wr(32'h04, 32'hABCD_EF00);
    send_word(stream[0], 0);
    send_word(stream[1], 0);
    wait_done("basic");
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);

    // Same stream with source gaps
    do_start(5'd2);
    expect_wr(32'h00, 32'h1234_5678);
    expect_wr(32'h04, 32'hABCD_EF00);
    for (int i = 0; i < 8; i++) send_byte(stream[i / 4][8 * (i % 4) +: 8], gaps[i]);
    wait_done("gaps");

    // Zero length completes immediately
    w0 = wr_cnt;
    do_start(5'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("len0_done_pulse", 32'(done), 32'd0);
    check("len0_no_write", 32'(wr_cnt - w0), 32'd0);

    // Length beyond depth is clamped to 16 words
    w0 = wr_cnt;
    do_start(5'd20);
    for (int i = 0; i < 16; i++) begin
      w = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      expect_wr(32'(i * 4), w);
      send_word(w, 0);
    end
    wait_done("clamp");
    check("clamp_write_count", 32'(wr_cnt - w0), 32'd16);
    check("clamp_last_addr", last_addr, 32'h3C);

    // Abort after two bytes
    w0 = wr_cnt;
    do_start(5'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    abort      = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_idle", 32'(byte_ready), 32'd0);
    check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    check("abort_addr_held", wr_addr, 32'h3C);
    check("abort_data_held", wr_data, 32'h3F3E_3D3C);
    repeat (2) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    do_start(5'd1);
    expect_wr(32'h00, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF, 1);
    wait_done("after_abort");

    // Simultaneous start and abort in IDLE is an abort
    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    load_len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_hold", 32'(cpu_hold), 32'd0);
    check("start_abort_ready", 32'(byte_ready), 32'd0);

    // Start during RECV is ignored; second word still lands at 0x04
    do_start(5'd2);
    expect_wr(32'h00, 32'hCAFE_0001);
    expect_wr(32'h04, 32'hBEEF_0002);
    send_word(32'hCAFE_0001, 0);
    send_byte(8'h02, 0);
    start    = 1'b1;
    load_len = 5'd5;
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    wait_done("restart_ignored");

    // Reset asserted while the second word is being written
    w0 = wr_cnt;
    do_start(5'd2);
    expect_wr(32'h00, 32'h5566_7788);
    send_word(32'h5566_7788, 0);
    send_word(32'h0BAD_F00D, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", wr_addr, 32'd0);
    check("midrst_wr_data", wr_data, 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) check("postrst_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    check("postrst_hold", 32'(cpu_hold), 32'd0);
    check("postrst_writes", 32'(wr_cnt - w0), 32'd1);

    check("total_done_count", 32'(done_cnt), 32'd6);
    check("final_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16, meaning the number of 32-bit words in the target instruction memory.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, load request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, cancels a load in progress.
REQ-006 SHALL have port load_len, input, 5, word count to load, sampled with start.
REQ-007 SHALL have port byte_valid, input, 1, source presents byte_data.
REQ-008 SHALL have port byte_data, input, 8, program byte stream, little-endian within each word.
REQ-009 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en, output, 1, one-cycle write strobe to instruction memory.
REQ-011 SHALL have port wr_addr, output, 32, word-aligned byte address (bits [1:0] = 0).
REQ-012 SHALL have port wr_data, output, 32, assembled instruction word.
REQ-013 SHALL have port cpu_hold, output, 1, holds the core stalled while loading.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RECV, WRITE, DONE.
REQ-016 In IDLE, start=1 and abort=0 SHALL latch len = min(load_len, DEPTH_WORDS), clear word_idx and byte_idx, and go to RECV; if len = 0, go directly to DONE.
REQ-017 In RECV, byte_ready SHALL be 1; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-018 Accepted byte k (k = 0..3) SHALL be placed in word bits [8k+7:8k]; after the 4th byte, go to WRITE on the next cycle.
REQ-019 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr = word_idx*4 and wr_data = the assembled word; byte_ready SHALL be 0.
REQ-020 After WRITE, word_idx SHALL increment; go to DONE if word_idx+1 = len, else return to RECV.
REQ-021 In DONE, done SHALL be 1 for one cycle, then return to IDLE.
REQ-022 cpu_hold SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-023 abort=1 in RECV or WRITE SHALL return to IDLE next cycle; the partial word is discarded; no wr_en is issued in that cycle; done stays 0.
REQ-024 In IDLE, simultaneous start and abort SHALL be treated as abort (no load).
REQ-025 start outside IDLE SHALL be ignored; byte_valid outside RECV SHALL not be consumed.
REQ-026 wr_addr and wr_data SHALL hold their last values when wr_en = 0.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, word_idx = 0, byte_idx = 0, and all outputs to 0, including wr_addr and wr_data.
REQ-028 Reset asserted mid-load SHALL abandon the load with no further writes; after release, the block waits for a new start.

Structure
REQ-029 Package imem_pkg SHALL hold IMEM_DEPTH = 16, the loader state enum, and the word/byte width constants.
REQ-030 Byte-to-word packing SHALL reside in sub-module byte_packer (byte counter plus shift register, with clear and full outputs).

Verification
REQ-031 start, load_len=2, then bytes 78 56 34 12 00 EF CD AB -> writes (0x00, 0x12345678) and (0x04, 0xABCDEF00); done pulses once; cpu_hold is high from the cycle after start until DONE.
REQ-032 Same stream with byte_valid gaps of 0-3 cycles -> identical writes; no byte is dropped or duplicated.
REQ-033 load_len=0 -> done one cycle after start, no wr_en; load_len=20 -> exactly 16 writes, the last at 0x3C.
REQ-034 abort after 2 bytes -> no wr_en, state IDLE, cpu_hold 0; a new load of 0xFFFFFFFF then writes (0x00, 0xFFFFFFFF).
REQ-035 rst_n pulsed low mid-WRITE sequence -> outputs 0 immediately; no write after reset release until a new start.
REQ-036 start re-asserted during RECV -> ignored; word_idx is not cleared.
